// File: rtl/id_ex_pkg.sv
// ============================================================================
//  Module : id_ex_pkg
//  Brief  : Shared types, bubble defaults and helpers for the ID/EX register
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ID_EX_SHARED_DEFINES
`define ID_EX_SHARED_DEFINES
`define INST_NOP  32'h00000013
`define ZERO_WORD 32'h0
`endif

package id_ex_pkg;

  // Decoded bundle carried from decode to execute
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr;
    logic        reg_wen;
  } bundle_t;

  // Bundle presented when nothing valid is held; reg_wen is always 0
  function automatic bundle_t bubble_bundle(input logic [31:0] nop_inst,
                                            input logic [31:0] bubble_addr);
    bundle_t b;
    b.inst      = nop_inst;
    b.inst_addr = bubble_addr;
    b.op1       = 32'h0;
    b.op2       = 32'h0;
    b.rd_addr   = 5'h0;
    b.reg_wen   = 1'b0;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_pipe_entry.sv
// ============================================================================
//  Module : pipe_entry
//  Brief  : One pipeline slot (valid bit + payload). Any invalidation writes
//           the bubble payload, so the outputs are always safe to consume.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_entry
  import id_ex_pkg::*;
#(
  parameter logic [31:0] NOP_INST    = `INST_NOP,
  parameter logic [31:0] BUBBLE_ADDR = `ZERO_WORD
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    clear,
  input  bundle_t d,
  output logic    valid,
  output bundle_t q
);

  // Slot register: reset/clear install a bubble, load captures a bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= bubble_bundle(NOP_INST, BUBBLE_ADDR);
    end else if (clear) begin
      valid <= 1'b0;
      q     <= bubble_bundle(NOP_INST, BUBBLE_ADDR);
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex.sv
// ============================================================================
//  Module : id_ex
//  Brief  : ID/EX pipeline register with 2-entry skid buffer, flush and
//           bubble-cycle counter. ready_o comes straight from a flop.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex
  import id_ex_pkg::*;
#(
  parameter logic [31:0] NOP_INST    = `INST_NOP,
  parameter logic [31:0] BUBBLE_ADDR = `ZERO_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wen_o,
  output logic [31:0] bubble_cnt_o
);

  bundle_t     in_bundle;
  bundle_t     m_q;
  bundle_t     s_q;
  bundle_t     m_d;
  logic        m_valid;
  logic        s_valid;
  logic        m_load;
  logic        m_clear;
  logic        s_load;
  logic        s_clear;
  logic        in_xfer;
  logic        m_free;
  logic [31:0] bubble_cnt;

  assign in_bundle = '{inst: inst_i, inst_addr: inst_addr_i, op1: op1_i,
                       op2: op2_i, rd_addr: rd_addr_i, reg_wen: reg_wen_i};

  // Skid slot occupancy alone decides ready, so there is no path from ready_i
  assign ready_o = !s_valid;
  assign in_xfer = valid_i & ready_o;
  assign m_free  = !m_valid | ready_i;

  // Steering: flush first, then refill M from S, then from input, else skid
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = in_bundle;
    if (flush_i) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (m_free) begin
      if (s_valid) begin
        m_load  = 1'b1;
        m_d     = s_q;
        s_clear = 1'b1;
      end else if (in_xfer) begin
        m_load  = 1'b1;
      end else begin
        m_clear = 1'b1;
      end
    end else if (in_xfer) begin
      s_load = 1'b1;
    end
  end

  pipe_entry #(.NOP_INST(NOP_INST), .BUBBLE_ADDR(BUBBLE_ADDR)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_q)
  );

  pipe_entry #(.NOP_INST(NOP_INST), .BUBBLE_ADDR(BUBBLE_ADDR)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s_load),
    .clear (s_clear),
    .d     (in_bundle),
    .valid (s_valid),
    .q     (s_q)
  );

  // Count edges on which execute was shown a bubble; flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 32'h0;
    end else if (!m_valid) begin
      bubble_cnt <= bubble_cnt + 32'h1;
    end
  end

  assign valid_o      = m_valid;
  assign inst_o       = m_q.inst;
  assign inst_addr_o  = m_q.inst_addr;
  assign op1_o        = m_q.op1;
  assign op2_o        = m_q.op2;
  assign rd_addr_o    = m_q.rd_addr;
  assign reg_wen_o    = m_q.reg_wen;
  assign bubble_cnt_o = bubble_cnt;

endmodule

`default_nettype wire
